// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder.
//   DATA_W    : data word width (16)
//   MMIO_ADDR : address decoded as board I/O (switches on read, hex display on write)
//   state_t   : responder FSM states
package mem_responder_pkg;

    localparam int          DATA_W    = 16;
    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mem_responder_sram_array.sv
// Single-port synchronous RAM, registered read (read-before-write on a
// shared address). Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word address, ADDR_BITS wide
//   wdata_i : write data
//   rdata_o : registered read data of the address presented on the previous edge
module sram_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int WIDTH     = DATA_W
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a strobe-driven CPU control unit. Reads and writes
// are handshaked with Mem_OE / Mem_WE and complete after WAIT_CYCLES edges
// counted from the edge that first samples the strobe. Address 16'hFFFF is
// memory-mapped I/O: reads return Switches, writes load Hex_out.
//   Clk, Reset      : clock, synchronous active-high reset
//   Mem_OE, Mem_WE  : read / write strobes (write wins if both high)
//   ADDR            : word address, latched at strobe start
//   Data_from_CPU   : write data, latched at strobe start
//   Data_to_CPU     : registered read data, held until the next read
//   Ready           : registered; high in RD_DONE / WR_DONE
//   Switches        : board switches (read at MMIO_ADDR)
//   Hex_out         : display register (written at MMIO_ADDR)
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       Data_from_CPU,
    output logic [15:0]       Data_to_CPU,
    output logic              Ready,
    input  logic [15:0]       Switches,
    output logic [15:0]       Hex_out
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [15:0]           addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic [DATA_W-1:0]     hex_q, hex_d;
    logic                  ready_q;

    logic                  commit;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    // In IDLE the RAM is addressed straight from ADDR so that the word is
    // already in the RAM output register one edge later; this is what lets a
    // WAIT_CYCLES=1 read capture data on the edge after the strobe is seen.
    assign ram_addr = (state_q == IDLE) ? ADDR[ADDR_BITS-1:0]
                                        : addr_q[ADDR_BITS-1:0];

    // Commit happens on the edge that leaves WR_WAIT with the strobe still
    // high. Gated by Reset so a reset edge can never write.
    assign commit = (state_q == WR_WAIT) && (cnt_q == 3'd0) && Mem_WE && !Reset;
    assign ram_we = commit && (addr_q != MMIO_ADDR);

    sram_array #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (DATA_W)
    ) u_sram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        hex_d   = hex_q;

        case (state_q)
            IDLE: begin
                if (Mem_WE) begin
                    addr_d  = ADDR;
                    wdata_d = Data_from_CPU;
                    cnt_d   = WAIT_LOAD;
                    state_d = WR_WAIT;
                end else if (Mem_OE) begin
                    addr_d  = ADDR;
                    cnt_d   = WAIT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    dout_d  = (addr_q == MMIO_ADDR) ? Switches : ram_rdata;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_DONE: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (!Mem_WE) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    if (addr_q == MMIO_ADDR) begin
                        hex_d = wdata_q;
                    end
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_DONE: begin
                // Held until the strobe drops so a long strobe commits once.
                if (!Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            wdata_q <= '0;
            dout_q  <= '0;
            hex_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            hex_q   <= hex_d;
            ready_q <= (state_d == RD_DONE) || (state_d == WR_DONE);
        end
    end

    assign Data_to_CPU = dout_q;
    assign Hex_out     = hex_q;
    assign Ready       = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Instance 0 uses WAIT_CYCLES=1,
// instance 1 uses WAIT_CYCLES=3. Inputs are driven and outputs sampled on
// the falling edge. Read expectations come from a bench-side memory model
// and are queued when the read is launched, then popped when Ready is seen.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  oe, we, rdy;
    logic [15:0] addr_s [2];
    logic [15:0] din_s  [2];
    logic [15:0] dout_s [2];
    logic [15:0] hex_s  [2];
    logic [15:0] Switches;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model    [2][256];
    logic [15:0] dout_exp [2];
    logic [15:0] hex_exp  [2];
    logic [15:0] sb_q [$];

    always #5 Clk = ~Clk;

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe[0]), .Mem_WE(we[0]),
        .ADDR(addr_s[0]), .Data_from_CPU(din_s[0]), .Data_to_CPU(dout_s[0]),
        .Ready(rdy[0]), .Switches(Switches), .Hex_out(hex_s[0])
    );

    mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(3)) dut1 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe[1]), .Mem_WE(we[1]),
        .ADDR(addr_s[1]), .Data_from_CPU(din_s[1]), .Data_to_CPU(dout_s[1]),
        .Ready(rdy[1]), .Switches(Switches), .Hex_out(hex_s[1])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    // Write: strobe held for 'hold' cycles; commit expected once hold covers
    // the sampling edge plus WAIT_CYCLES edges.
    task automatic do_write(input int s, input logic [15:0] a, input logic [15:0] d,
                            input int hold, input bit scramble, input bit with_oe);
        int lat;
        bit done;
        lat = lat_of(s);
        done = (hold >= lat + 1);
        we[s] = 1'b1; oe[s] = with_oe; addr_s[s] = a; din_s[s] = d;
        for (int i = 1; i <= hold; i++) begin
            @(negedge Clk);
            check($sformatf("wr_ready_dut%0d_c%0d", s, i), {15'd0, rdy[s]},
                  (i >= lat + 1) ? 16'd1 : 16'd0);
            if (scramble) begin
                din_s[s]  = 16'($urandom);
                addr_s[s] = 16'($urandom);
            end
        end
        we[s] = 1'b0; oe[s] = 1'b0;
        if (done) begin
            if (a == 16'hFFFF) hex_exp[s] = d;
            else model[s][a[7:0]] = d;
        end
        @(negedge Clk);
        check($sformatf("wr_release_dut%0d", s), {15'd0, rdy[s]}, 16'd0);
        check($sformatf("wr_hex_dut%0d", s), hex_s[s], hex_exp[s]);
        if (with_oe) check($sformatf("wr_dout_hold_dut%0d", s), dout_s[s], dout_exp[s]);
        $display("txn write dut%0d addr=%h data=%h hold=%0d committed=%0d", s, a, d, hold, done);
    endtask

    task automatic do_read(input int s, input logic [15:0] a, input int hold);
        int lat;
        logic [15:0] exp;
        lat = lat_of(s);
        if (hold >= lat + 1)
            sb_q.push_back((a == 16'hFFFF) ? Switches : model[s][a[7:0]]);
        oe[s] = 1'b1; addr_s[s] = a;
        for (int i = 1; i <= hold; i++) begin
            @(negedge Clk);
            check($sformatf("rd_ready_dut%0d_c%0d", s, i), {15'd0, rdy[s]},
                  (i >= lat + 1) ? 16'd1 : 16'd0);
            if (i == lat + 1) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $error("FAIL rd_sb_empty observed=empty expected=entry");
                end else begin
                    exp = sb_q.pop_front();
                    check($sformatf("rd_data_dut%0d_%h", s, a), dout_s[s], exp);
                    dout_exp[s] = exp;
                end
            end
            addr_s[s] = 16'($urandom);
        end
        oe[s] = 1'b0;
        @(negedge Clk);
        check($sformatf("rd_release_dut%0d", s), {15'd0, rdy[s]}, 16'd0);
        check($sformatf("rd_dout_keep_dut%0d", s), dout_s[s], dout_exp[s]);
        $display("txn read dut%0d addr=%h hold=%0d data=%h", s, a, hold, dout_s[s]);
    endtask

    initial begin
        Reset = 1'b1; oe = '0; we = '0; Switches = 16'h0000;
        for (int s = 0; s < 2; s++) begin
            addr_s[s] = 16'h0; din_s[s] = 16'h0; dout_exp[s] = 16'h0; hex_exp[s] = 16'h0;
        end
        repeat (2) @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_ready_dut%0d", s), {15'd0, rdy[s]}, 16'd0);
            check($sformatf("rst_dout_dut%0d", s), dout_s[s], 16'h0000);
            check($sformatf("rst_hex_dut%0d", s), hex_s[s], 16'h0000);
        end
        Reset = 1'b0;
        @(negedge Clk);

        // Write then read
        do_write(0, 16'h0012, 16'hBEEF, 2, 1'b0, 1'b0);
        do_read (0, 16'h0012, 2);

        // MMIO, with RAM[0xFF] guarded
        Switches = 16'h00A5;
        do_write(0, 16'h00FF, 16'h7777, 2, 1'b0, 1'b0);
        do_read (0, 16'hFFFF, 2);
        do_write(0, 16'hFFFF, 16'h1234, 2, 1'b0, 1'b0);
        do_read (0, 16'h00FF, 2);

        // Aliasing of upper address bits
        do_write(0, 16'h0112, 16'h5555, 2, 1'b0, 1'b0);
        do_read (0, 16'h0012, 2);

        // Both strobes: write wins, read data untouched
        do_write(0, 16'h0030, 16'h0F0F, 2, 1'b0, 1'b1);
        do_read (0, 16'h0030, 2);

        // Long strobe with changing inputs: single commit of first data
        do_write(0, 16'h0050, 16'hA1A1, 10, 1'b1, 1'b0);
        do_read (0, 16'h0050, 2);

        // WAIT_CYCLES=3: full transactions
        do_write(1, 16'h0040, 16'h1111, 4, 1'b1, 1'b0);
        do_read (1, 16'h0040, 4);

        // Write aborted after 2 cycles: no commit
        do_write(1, 16'h0040, 16'h2222, 2, 1'b0, 1'b0);
        do_read (1, 16'h0040, 4);

        // Read aborted: data register unchanged
        do_write(1, 16'h0041, 16'h3333, 4, 1'b0, 1'b0);
        do_read (1, 16'h0041, 2);

        // Reset while in WR_WAIT
        we[1] = 1'b1; addr_s[1] = 16'h0040; din_s[1] = 16'hDEAD;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("rstmid_ready_dut1", {15'd0, rdy[1]}, 16'd0);
        check("rstmid_dout_dut1", dout_s[1], 16'h0000);
        check("rstmid_hex_dut0", hex_s[0], 16'h0000);
        $display("txn reset-abort dut1 addr=0040 data=dead");
        Reset = 1'b0; we[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            dout_exp[s] = 16'h0; hex_exp[s] = 16'h0;
        end
        @(negedge Clk);
        do_read(1, 16'h0040, 4);
        do_read(0, 16'h0112, 2);

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning the internal RAM depth is 2**ADDR_BITS words of 16 bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1 (legal range 1..7), meaning the number of clock edges from the first sampled strobe to data-valid or write-commit.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Mem_OE, input, 1 bit: active-high read strobe from the control unit.
REQ-006 SHALL have port Mem_WE, input, 1 bit: active-high write strobe from the control unit.
REQ-007 SHALL have port ADDR, input, 16 bits: word address (MAR).
REQ-008 SHALL have port Data_from_CPU, input, 16 bits: write data (MDR).
REQ-009 SHALL have port Data_to_CPU, output, 16 bits: read data, sampled by the control unit on its LD_MDR edge.
REQ-010 SHALL have port Ready, output, 1 bit: high while read data is valid or after a write has committed.
REQ-011 SHALL have port Switches, input, 16 bits: board switches mapped at address 16'hFFFF.
REQ-012 SHALL have port Hex_out, output, 16 bits: display register mapped at address 16'hFFFF.

Function
REQ-013 SHALL implement states IDLE, RD_WAIT, RD_DONE, WR_WAIT and WR_DONE.
REQ-014 In IDLE, with Mem_WE high, SHALL latch ADDR and Data_from_CPU, load the wait counter with WAIT_CYCLES-1, and go to WR_WAIT. Mem_WE has priority over Mem_OE when both are high.
REQ-015 In IDLE, with Mem_OE high and Mem_WE low, SHALL latch ADDR, load the wait counter, and go to RD_WAIT.
REQ-016 In RD_WAIT, with counter equal to 0, SHALL register the read word into Data_to_CPU and go to RD_DONE; otherwise SHALL decrement the counter.
REQ-017 Total read latency SHALL be exactly WAIT_CYCLES edges. With the default value, Data_to_CPU is valid in the second Mem_OE cycle, which matches a two-cycle read (fetch cycles 1 and 2, LD_MDR in cycle 2).
REQ-018 In WR_WAIT, with counter equal to 0, SHALL commit the latched data to the latched address and go to WR_DONE; otherwise SHALL decrement the counter.
REQ-019 SHALL commit at most once per contiguous Mem_WE assertion; WR_DONE stays until Mem_WE is low.
REQ-020 Ready SHALL be 1 only in RD_DONE and WR_DONE (registered, no combinational path from strobes).
REQ-021 In RD_DONE, SHALL hold Data_to_CPU stable and return to IDLE on the first edge with Mem_OE low. Data_to_CPU retains its last value in IDLE.
REQ-022 If the active strobe drops in RD_WAIT, SHALL abort to IDLE with Data_to_CPU unchanged. If it drops in WR_WAIT, SHALL abort to IDLE with no commit.
REQ-023 Address 16'hFFFF SHALL read Switches, sampled at the data-register edge. A write to 16'hFFFF SHALL load Hex_out and leave RAM untouched.
REQ-024 All other addresses SHALL index RAM by ADDR[ADDR_BITS-1:0], so upper bits alias (wrap-around).
REQ-025 The address and data latched at strobe start SHALL be used; changes to ADDR and Data_from_CPU mid-transaction SHALL be ignored.
REQ-026 A strobe rising in the same edge that returns to IDLE SHALL NOT start a transaction; a new transaction requires the strobe to be sampled high while in IDLE.

Reset
REQ-027 On Reset, SHALL go to IDLE, with Ready=0, Data_to_CPU=16'h0000, Hex_out=16'h0000 and counter=0.
REQ-028 Reset mid-transaction SHALL abort it; no RAM or Hex_out write SHALL occur on the reset edge.
REQ-029 RAM contents SHALL NOT be cleared by Reset.

Structure
REQ-030 A shared package SHALL hold the state enum, MMIO_ADDR = 16'hFFFF and the data-width constant of 16.
REQ-031 RAM storage SHALL be a sub-module, sram_array (single port, synchronous write, registered read), instantiated once.
REQ-032 Total RTL SHALL be within 120-400 lines.

Verification
REQ-033 Write then read: Mem_WE high for 2 cycles with ADDR=16'h0012, data 16'hBEEF; then Mem_OE for 2 cycles at 16'h0012 -> Data_to_CPU = 16'hBEEF in the 2nd OE cycle, and Ready = 1.
REQ-034 MMIO: Switches=16'h00A5, read 16'hFFFF -> 16'h00A5; write 16'h1234 to 16'hFFFF -> Hex_out = 16'h1234, and RAM[16'h00FF] is unchanged.
REQ-035 Aliasing: write 16'h5555 to 16'h0112 (ADDR_BITS=8) -> a read of 16'h0012 returns 16'h5555.
REQ-036 Abort and reset: WAIT_CYCLES=3 with Mem_WE dropped after 2 cycles -> no commit. Reset asserted in WR_WAIT -> IDLE, Ready = 0, and the target word holds its old value.
REQ-037 Simultaneous strobes: Mem_OE=Mem_WE=1 with data 16'h0F0F -> a write is committed and Data_to_CPU is unchanged.
REQ-038 Long strobe: Mem_WE held 10 cycles while Data_from_CPU changes each cycle -> exactly one commit, of the data latched in the first cycle.
